// File: rtl/soc_pwr_seq.sv
// ---------------------------------------------------------------------------
// soc_pwr_seq : per-domain PLL program / lock / clock-enable / reset sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module soc_pwr_seq #(
   parameter int NUM_DOM      = 3,
   parameter int REF_DIV_BW   = 4,
   parameter int FB_DIV_BW    = 12,
   parameter int DEF_REF_DIV  = 1,
   parameter int DEF_FB_DIV   = 10,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int CLK_RST_DLY  = 16,
   localparam int DW          = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            cmd_valid_i,
   output logic                            cmd_ready_o,
   input  logic [DW-1:0]                   cmd_dom_i,
   input  logic                            cmd_up_i,
   input  logic [REF_DIV_BW-1:0]           cmd_ref_div_i,
   input  logic [FB_DIV_BW-1:0]            cmd_fb_div_i,
   output logic [NUM_DOM*REF_DIV_BW-1:0]   pll_ref_div_o,
   output logic [NUM_DOM*FB_DIV_BW-1:0]    pll_fb_div_o,
   input  logic [NUM_DOM-1:0]              pll_locked_i,
   output logic [NUM_DOM-1:0]              clk_en_o,
   output logic [NUM_DOM-1:0]              arst_n_o,
   output logic [NUM_DOM-1:0]              dom_on_o,
   output logic [NUM_DOM-1:0]              lock_lost_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            err_o
);

   localparam int CNT_MAX = (LOCK_TIMEOUT > CLK_RST_DLY) ? LOCK_TIMEOUT : CLK_RST_DLY;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(CLK_RST_DLY - 1);
   localparam logic [CW-1:0] SETTLE   = CW'(2);

   localparam logic [NUM_DOM*REF_DIV_BW-1:0] REF_RST = {NUM_DOM{REF_DIV_BW'(DEF_REF_DIV)}};
   localparam logic [NUM_DOM*FB_DIV_BW-1:0]  FB_RST  = {NUM_DOM{FB_DIV_BW'(DEF_FB_DIV)}};

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PROG       = 3'd1,
      LOCK_WAIT  = 3'd2,
      CLK_EN     = 3'd3,
      RST_REL    = 3'd4,
      RST_ASSERT = 3'd5,
      CLK_DIS    = 3'd6,
      DONE       = 3'd7
   } state_t;

   state_t                          state, state_nx;
   logic [CW-1:0]                   cnt, cnt_nx;
   logic                            err_flag, err_flag_nx;
   logic [NUM_DOM-1:0]              dom_sel, dom_sel_nx;
   logic [NUM_DOM-1:0]              clk_en, clk_en_nx;
   logic [NUM_DOM-1:0]              arst_n, arst_n_nx;
   logic [NUM_DOM-1:0]              dom_on, dom_on_nx;
   logic [NUM_DOM-1:0]              lock_lost, lock_lost_nx;
   logic [NUM_DOM*REF_DIV_BW-1:0]   ref_div, ref_div_nx;
   logic [NUM_DOM*FB_DIV_BW-1:0]    fb_div, fb_div_nx;

   logic [NUM_DOM-1:0]              cmd_hot;
   logic [NUM_DOM-1:0]              mon_mask;
   logic [NUM_DOM-1:0]              lost;
   logic                            dom_valid;
   logic                            dom_is_on;
   logic                            cur_locked;
   logic                            seq_active;

   // One-hot decode of the requested domain; an out-of-range index decodes to zero.
   always_comb begin
      cmd_hot = '0;
      for (int d = 0; d < NUM_DOM; d++) begin
         cmd_hot[d] = (cmd_dom_i == DW'(d));
      end
   end

   assign dom_valid  = |cmd_hot;
   assign dom_is_on  = |(cmd_hot & dom_on);
   assign cur_locked = |(dom_sel & pll_locked_i);
   assign seq_active = (state != IDLE) && (state != DONE);
   assign mon_mask   = seq_active ? ~dom_sel : '1;
   assign lost       = dom_on & ~pll_locked_i & mon_mask;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         err_flag  <= 1'b0;
         dom_sel   <= '0;
         clk_en    <= '0;
         arst_n    <= '0;
         dom_on    <= '0;
         lock_lost <= '0;
         ref_div   <= REF_RST;
         fb_div    <= FB_RST;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         err_flag  <= err_flag_nx;
         dom_sel   <= dom_sel_nx;
         clk_en    <= clk_en_nx;
         arst_n    <= arst_n_nx;
         dom_on    <= dom_on_nx;
         lock_lost <= lock_lost_nx;
         ref_div   <= ref_div_nx;
         fb_div    <= fb_div_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      err_flag_nx  = err_flag;
      dom_sel_nx   = dom_sel;
      clk_en_nx    = clk_en & ~lost;
      arst_n_nx    = arst_n & ~lost;
      dom_on_nx    = dom_on & ~lost;
      lock_lost_nx = lock_lost | lost;
      ref_div_nx   = ref_div;
      fb_div_nx    = fb_div;

      case (state)
         IDLE: begin
            if (cmd_valid_i) begin
               dom_sel_nx  = cmd_hot;
               cnt_nx      = '0;
               err_flag_nx = 1'b0;
               if (!dom_valid) begin
                  state_nx    = DONE;
                  err_flag_nx = 1'b1;
               end else if (cmd_up_i == dom_is_on) begin
                  state_nx = DONE;
               end else if (cmd_up_i) begin
                  state_nx     = PROG;
                  lock_lost_nx = lock_lost_nx & ~cmd_hot;
                  clk_en_nx    = clk_en_nx & ~cmd_hot;
                  arst_n_nx    = arst_n_nx & ~cmd_hot;
                  for (int d = 0; d < NUM_DOM; d++) begin
                     if (cmd_hot[d]) begin
                        ref_div_nx[d*REF_DIV_BW +: REF_DIV_BW] = cmd_ref_div_i;
                        fb_div_nx[d*FB_DIV_BW +: FB_DIV_BW]    = cmd_fb_div_i;
                     end
                  end
               end else begin
                  state_nx  = RST_ASSERT;
                  arst_n_nx = arst_n_nx & ~cmd_hot;
                  dom_on_nx = dom_on_nx & ~cmd_hot;
               end
            end
         end

         PROG: begin
            state_nx = LOCK_WAIT;
            cnt_nx   = '0;
         end

         // Lock is ignored for the first two cycles while the PLL settles.
         LOCK_WAIT: begin
            if ((cnt >= SETTLE) && cur_locked) begin
               state_nx  = CLK_EN;
               cnt_nx    = '0;
               clk_en_nx = clk_en_nx | dom_sel;
            end else if (cnt == TO_LAST) begin
               state_nx    = DONE;
               err_flag_nx = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         CLK_EN, RST_REL: begin
            if (!cur_locked) begin
               state_nx     = DONE;
               err_flag_nx  = 1'b1;
               clk_en_nx    = clk_en_nx & ~dom_sel;
               arst_n_nx    = arst_n_nx & ~dom_sel;
               dom_on_nx    = dom_on_nx & ~dom_sel;
               lock_lost_nx = lock_lost_nx | dom_sel;
            end else if (state == RST_REL) begin
               state_nx = DONE;
            end else if (cnt == DLY_LAST) begin
               state_nx  = RST_REL;
               cnt_nx    = '0;
               arst_n_nx = arst_n_nx | dom_sel;
               dom_on_nx = dom_on_nx | dom_sel;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         RST_ASSERT: begin
            if (cnt == DLY_LAST) begin
               state_nx  = CLK_DIS;
               cnt_nx    = '0;
               clk_en_nx = clk_en_nx & ~dom_sel;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         CLK_DIS: state_nx = DONE;

         DONE:    state_nx = IDLE;

         default: state_nx = IDLE;
      endcase
   end

   assign cmd_ready_o   = (state == IDLE);
   assign busy_o        = (state != IDLE);
   assign done_o        = (state == DONE);
   assign err_o         = (state == DONE) && err_flag;
   assign clk_en_o      = clk_en;
   assign arst_n_o      = arst_n;
   assign dom_on_o      = dom_on;
   assign lock_lost_o   = lock_lost;
   assign pll_ref_div_o = ref_div;
   assign pll_fb_div_o  = fb_div;

endmodule

`default_nettype wire

// File: tb/tb_soc_pwr_seq.sv
// ---------------------------------------------------------------------------
// tb_soc_pwr_seq : directed stimulus with a done-triggered scoreboard
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_soc_pwr_seq;

   localparam int NUM_DOM = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_dom;
   logic        cmd_up;
   logic [3:0]  cmd_ref;
   logic [11:0] cmd_fb;
   logic [11:0] ref_div;
   logic [35:0] fb_div;
   logic [2:0]  lock;
   logic [2:0]  clk_en;
   logic [2:0]  arst_n;
   logic [2:0]  dom_on;
   logic [2:0]  lock_lost;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        err;
      logic [2:0]  ce;
      logic [2:0]  an;
      logic [2:0]  on;
      logic [2:0]  ll;
      logic [11:0] rd;
      logic [35:0] fd;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   soc_pwr_seq #(
      .NUM_DOM      (NUM_DOM),
      .REF_DIV_BW   (4),
      .FB_DIV_BW    (12),
      .DEF_REF_DIV  (1),
      .DEF_FB_DIV   (10),
      .LOCK_TIMEOUT (64),
      .CLK_RST_DLY  (4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_dom_i     (cmd_dom),
      .cmd_up_i      (cmd_up),
      .cmd_ref_div_i (cmd_ref),
      .cmd_fb_div_i  (cmd_fb),
      .pll_ref_div_o (ref_div),
      .pll_fb_div_o  (fb_div),
      .pll_locked_i  (lock),
      .clk_en_o      (clk_en),
      .arst_n_o      (arst_n),
      .dom_on_o      (dom_on),
      .lock_lost_o   (lock_lost),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic e, input logic [2:0] ce, input logic [2:0] an,
                           input logic [2:0] on, input logic [2:0] ll,
                           input logic [11:0] rd, input logic [35:0] fd);
      exp_t x;
      x.err = e; x.ce = ce; x.an = an; x.on = on; x.ll = ll; x.rd = rd; x.fd = fd;
      sb.push_back(x);
   endtask

   task automatic send(input logic [1:0] dom, input logic up, input logic [3:0] rdv,
                       input logic [11:0] fdv);
      int n = 0;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      chk("ready_wait", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1;
      cmd_dom   = dom;
      cmd_up    = up;
      cmd_ref   = rdv;
      cmd_fb    = fdv;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      chk("idle_wait", 64'(busy), 64'(0));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_clk_en"}, 64'(clk_en), 64'(0));
      chk({tag, "_arst_n"}, 64'(arst_n), 64'(0));
      chk({tag, "_dom_on"}, 64'(dom_on), 64'(0));
      chk({tag, "_lock_lost"}, 64'(lock_lost), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_err"}, 64'(err), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_ref_div"}, 64'(ref_div), 64'({4'd1, 4'd1, 4'd1}));
      chk({tag, "_fb_div"}, 64'(fb_div), 64'({12'd10, 12'd10, 12'd10}));
   endtask

   // Scoreboard monitor: every done pulse retires the oldest expected outcome.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending command");
         end else begin
            mon_e = sb.pop_front();
            chk("done_err", 64'(err), 64'(mon_e.err));
            chk("done_clk_en", 64'(clk_en), 64'(mon_e.ce));
            chk("done_arst_n", 64'(arst_n), 64'(mon_e.an));
            chk("done_dom_on", 64'(dom_on), 64'(mon_e.on));
            chk("done_lock_lost", 64'(lock_lost), 64'(mon_e.ll));
            chk("done_ref_div", 64'(ref_div), 64'(mon_e.rd));
            chk("done_fb_div", 64'(fb_div), 64'(mon_e.fd));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100us");
      $fatal(1);
   end

   initial begin
      int n;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_dom   = '0;
      cmd_up    = 1'b0;
      cmd_ref   = '0;
      cmd_fb    = '0;
      lock      = 3'b000;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_reset_vals("reset");
      chk("reset_ready", 64'(cmd_ready), 64'(1));

      // Up dom 1, lock arrives 5 cycles into LOCK_WAIT.
      push_exp(1'b0, 3'b010, 3'b010, 3'b010, 3'b000,
               {4'd1, 4'd2, 4'd1}, {12'd10, 12'd50, 12'd10});
      send(2'd1, 1'b1, 4'd2, 12'd50);
      chk("up1_ref_slice", 64'(ref_div[7:4]), 64'(2));
      chk("up1_fb_slice", 64'(fb_div[23:12]), 64'(50));
      chk("up1_ready_low", 64'(cmd_ready), 64'(0));
      chk("up1_clk_en_prog", 64'(clk_en[1]), 64'(0));
      repeat (6) tick();
      chk("up1_clk_en_prelock", 64'(clk_en[1]), 64'(0));
      lock[1] = 1'b1;
      tick();
      chk("up1_clk_en_rise", 64'(clk_en[1]), 64'(1));
      chk("up1_arst_n_held", 64'(arst_n[1]), 64'(0));
      repeat (3) tick();
      chk("up1_arst_n_early", 64'(arst_n[1]), 64'(0));
      tick();
      chk("up1_arst_n_rise", 64'(arst_n[1]), 64'(1));
      chk("up1_dom_on", 64'(dom_on[1]), 64'(1));
      wait_idle();

      // Up dom 2 with no lock: one PROG cycle plus 64 LOCK_WAIT cycles.
      push_exp(1'b1, 3'b010, 3'b010, 3'b010, 3'b000,
               {4'd3, 4'd2, 4'd1}, {12'd100, 12'd50, 12'd10});
      send(2'd2, 1'b1, 4'd3, 12'd100);
      n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      chk("timeout_latency", 64'(n), 64'(65));
      chk("timeout_err", 64'(err), 64'(1));
      wait_idle();

      // Down dom 1: reset first, clock removed 4 cycles later.
      push_exp(1'b0, 3'b000, 3'b000, 3'b000, 3'b000,
               {4'd3, 4'd2, 4'd1}, {12'd100, 12'd50, 12'd10});
      send(2'd1, 1'b0, 4'd0, 12'd0);
      chk("down1_arst_n", 64'(arst_n[1]), 64'(0));
      chk("down1_dom_on", 64'(dom_on[1]), 64'(0));
      chk("down1_clk_kept", 64'(clk_en[1]), 64'(1));
      repeat (3) tick();
      chk("down1_clk_still", 64'(clk_en[1]), 64'(1));
      tick();
      chk("down1_clk_off", 64'(clk_en[1]), 64'(0));
      wait_idle();

      // Dom 0 up, then lose lock while idle.
      lock[0] = 1'b1;
      push_exp(1'b0, 3'b001, 3'b001, 3'b001, 3'b000,
               {4'd3, 4'd2, 4'd1}, {12'd100, 12'd50, 12'd20});
      send(2'd0, 1'b1, 4'd1, 12'd20);
      wait_idle();
      chk("mon_pre_dom_on", 64'(dom_on[0]), 64'(1));
      lock[0] = 1'b0;
      tick();
      chk("mon_clk_en", 64'(clk_en[0]), 64'(0));
      chk("mon_arst_n", 64'(arst_n[0]), 64'(0));
      chk("mon_dom_on", 64'(dom_on[0]), 64'(0));
      chk("mon_lock_lost", 64'(lock_lost[0]), 64'(1));
      lock[0] = 1'b1;
      push_exp(1'b0, 3'b001, 3'b001, 3'b001, 3'b000,
               {4'd3, 4'd2, 4'd5}, {12'd100, 12'd50, 12'd30});
      send(2'd0, 1'b1, 4'd5, 12'd30);
      chk("reup_lock_lost_clr", 64'(lock_lost[0]), 64'(0));
      wait_idle();

      // Invalid domain and redundant up: no output changes.
      push_exp(1'b1, 3'b001, 3'b001, 3'b001, 3'b000,
               {4'd3, 4'd2, 4'd5}, {12'd100, 12'd50, 12'd30});
      send(2'd3, 1'b1, 4'd9, 12'd9);
      wait_idle();
      push_exp(1'b0, 3'b001, 3'b001, 3'b001, 3'b000,
               {4'd3, 4'd2, 4'd5}, {12'd100, 12'd50, 12'd30});
      send(2'd0, 1'b1, 4'd7, 12'd77);
      wait_idle();

      // Reset in the middle of LOCK_WAIT.
      send(2'd2, 1'b1, 4'd9, 12'd99);
      repeat (3) tick();
      chk("rst_lw_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      tick();
      check_reset_vals("rst_lw");
      rst = 1'b0;
      tick();
      chk("rst_lw_ready", 64'(cmd_ready), 64'(1));

      // Reset in the middle of CLK_EN.
      lock = 3'b111;
      send(2'd1, 1'b1, 4'd2, 12'd40);
      repeat (4) tick();
      chk("rst_ce_clk_en", 64'(clk_en[1]), 64'(1));
      rst = 1'b1;
      tick();
      check_reset_vals("rst_ce");
      rst = 1'b0;
      tick();
      chk("rst_ce_ready", 64'(cmd_ready), 64'(1));

      // Lock drop on the sequenced domain during CLK_EN aborts with error.
      push_exp(1'b1, 3'b000, 3'b000, 3'b000, 3'b100,
               {4'd4, 4'd1, 4'd1}, {12'd44, 12'd10, 12'd10});
      send(2'd2, 1'b1, 4'd4, 12'd44);
      repeat (4) tick();
      chk("abort_clk_en_on", 64'(clk_en[2]), 64'(1));
      lock[2] = 1'b0;
      tick();
      chk("abort_clk_en_off", 64'(clk_en[2]), 64'(0));
      chk("abort_lock_lost", 64'(lock_lost[2]), 64'(1));
      chk("abort_done", 64'(done), 64'(1));
      wait_idle();

      tick();
      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
